// File: rtl/soc_fifo_pkg.sv
// Shared definitions for the parametrised FIFO: CSR word addresses, STATUS/EVENT bit positions
// and the status layout. Used by soc_param_fifo_ctrl (optional IRQ logic: SOC_FIFO_IRQ_EN).
package soc_fifo_pkg;

  localparam logic [2:0] CSR_LEVEL   = 3'd0;
  localparam logic [2:0] CSR_STATUS  = 3'd1;
  localparam logic [2:0] CSR_EVENT   = 3'd2;
  localparam logic [2:0] CSR_IENABLE = 3'd3;
  localparam logic [2:0] CSR_AF_THR  = 3'd4;
  localparam logic [2:0] CSR_AE_THR  = 3'd5;

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_AF    = 2;
  localparam int ST_AE    = 3;
  localparam int ST_OF    = 4;
  localparam int ST_UF    = 5;
  localparam int ST_W     = 6;

  // Level-derived flags raise their event only on a rising edge; OF/UF raise it every cycle they are set.
  localparam logic [ST_W-1:0] EDGE_MASK =
    ST_W'((1 << ST_FULL) | (1 << ST_EMPTY) | (1 << ST_AF) | (1 << ST_AE));

  typedef struct packed {
    logic uf;
    logic of;
    logic ae;
    logic af;
    logic empty;
    logic full;
  } fifo_status_t;

endpackage

// File: rtl/soc_fifo_ram.sv
// FIFO storage: DEPTH x DATA_W words, one synchronous write port and one asynchronous
// (show-ahead) read port so the head word is visible without a read cycle.
module soc_fifo_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/soc_param_fifo_ctrl.sv
// Single-clock FIFO with Avalon-MM push/pop slaves and a CSR slave (level, status, thresholds).
// Define SOC_FIFO_IRQ_EN to build the sticky EVENT/IENABLE registers and the level interrupt.
module soc_param_fifo_ctrl
  import soc_fifo_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int AF_DEF = 12,
  parameter int AE_DEF = 2
) (
  input  logic        wrclock,
  input  logic        reset_n,
  input  logic        avalonmm_write_slave_write,
  input  logic [31:0] avalonmm_write_slave_writedata,
  output logic        avalonmm_write_slave_waitrequest,
  input  logic        avalonmm_read_slave_read,
  output logic [31:0] avalonmm_read_slave_readdata,
  output logic        avalonmm_read_slave_waitrequest,
  input  logic [2:0]  wrclk_control_slave_address,
  input  logic        wrclk_control_slave_read,
  input  logic        wrclk_control_slave_write,
  input  logic [31:0] wrclk_control_slave_writedata,
  output logic [31:0] wrclk_control_slave_readdata,
  output logic        wrclk_control_slave_irq
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic [LVL_W-1:0]  level_reg, level_next;
  logic [LVL_W-1:0]  af_thr_reg, ae_thr_reg;
  logic [31:0]       csr_rdata_reg, csr_rdata_next;
  logic [ST_W-1:0]   status_bits;
  logic [ST_W-1:0]   event_rd, ienable_rd;
  logic [DATA_W-1:0] head_word;
  logic              full, empty, push, pop, csr_wr;
  logic              unused_bits;

  // Flow control uses only the registered level, so a same-cycle pop never frees a full FIFO.
  assign full  = (level_reg == LVL_FULL);
  assign empty = (level_reg == '0);
  assign push  = avalonmm_write_slave_write && !full;
  assign pop   = avalonmm_read_slave_read && !empty;
  assign csr_wr = wrclk_control_slave_write;

  assign avalonmm_write_slave_waitrequest = full;
  assign avalonmm_read_slave_waitrequest  = empty;
  assign wrclk_control_slave_readdata     = csr_rdata_reg;
  assign unused_bits = ^{avalonmm_write_slave_writedata, wrclk_control_slave_writedata};

  soc_fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk   (wrclock),
    .we    (push),
    .waddr (wr_ptr_reg),
    .wdata (avalonmm_write_slave_writedata[DATA_W-1:0]),
    .raddr (rd_ptr_reg),
    .rdata (head_word)
  );

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_rdata
      if (gi < DATA_W) begin : g_used
        assign avalonmm_read_slave_readdata[gi] = head_word[gi];
      end else begin : g_pad
        assign avalonmm_read_slave_readdata[gi] = 1'b0;
      end
    end
  endgenerate

  always_comb begin
    level_next = level_reg;
    case ({push, pop})
      2'b10:   level_next = level_reg + LVL_W'(1);
      2'b01:   level_next = level_reg - LVL_W'(1);
      default: level_next = level_reg;
    endcase
  end

  always_comb begin
    status_bits           = '0;
    status_bits[ST_FULL]  = full;
    status_bits[ST_EMPTY] = empty;
    status_bits[ST_AF]    = (level_reg >= af_thr_reg);
    status_bits[ST_AE]    = (level_reg <= ae_thr_reg);
    status_bits[ST_OF]    = avalonmm_write_slave_write && full;
    status_bits[ST_UF]    = avalonmm_read_slave_read && empty;
  end

  always_comb begin
    csr_rdata_next = '0;
    case (wrclk_control_slave_address)
      CSR_LEVEL:   csr_rdata_next = {{(32-LVL_W){1'b0}}, level_reg};
      CSR_STATUS:  csr_rdata_next = {{(32-ST_W){1'b0}}, status_bits};
      CSR_EVENT:   csr_rdata_next = {{(32-ST_W){1'b0}}, event_rd};
      CSR_IENABLE: csr_rdata_next = {{(32-ST_W){1'b0}}, ienable_rd};
      CSR_AF_THR:  csr_rdata_next = {{(32-LVL_W){1'b0}}, af_thr_reg};
      CSR_AE_THR:  csr_rdata_next = {{(32-LVL_W){1'b0}}, ae_thr_reg};
      default:     csr_rdata_next = '0;
    endcase
  end

  always_ff @(posedge wrclock) begin
    if (!reset_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      level_reg     <= '0;
      af_thr_reg    <= LVL_W'(AF_DEF);
      ae_thr_reg    <= LVL_W'(AE_DEF);
      csr_rdata_reg <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      level_reg <= level_next;
      if (csr_wr && wrclk_control_slave_address == CSR_AF_THR) begin
        af_thr_reg <= wrclk_control_slave_writedata[LVL_W-1:0];
      end
      if (csr_wr && wrclk_control_slave_address == CSR_AE_THR) begin
        ae_thr_reg <= wrclk_control_slave_writedata[LVL_W-1:0];
      end
      if (wrclk_control_slave_read) begin
        csr_rdata_reg <= csr_rdata_next;
      end
    end
  end

`ifdef SOC_FIFO_IRQ_EN
  // Previous-status reset value matches the flags of an empty FIFO so reset itself raises no event.
  localparam logic [ST_W-1:0] STATUS_RST =
    ST_W'((1 << ST_EMPTY) | (1 << ST_AE) | ((AF_DEF == 0) ? (1 << ST_AF) : 0));

  logic [ST_W-1:0] event_reg, ienable_reg, status_prev_reg;
  logic [ST_W-1:0] event_set, event_clr;
  logic            irq_reg;

  always_comb begin
    event_set = status_bits & ~(status_prev_reg & EDGE_MASK);
    event_clr = '0;
    if (csr_wr && wrclk_control_slave_address == CSR_EVENT) begin
      event_clr = wrclk_control_slave_writedata[ST_W-1:0];
    end
  end

  always_ff @(posedge wrclock) begin
    if (!reset_n) begin
      event_reg       <= '0;
      ienable_reg     <= '0;
      status_prev_reg <= STATUS_RST;
      irq_reg         <= 1'b0;
    end else begin
      event_reg       <= (event_reg & ~event_clr) | event_set;
      status_prev_reg <= status_bits;
      irq_reg         <= |(event_reg & ienable_reg);
      if (csr_wr && wrclk_control_slave_address == CSR_IENABLE) begin
        ienable_reg <= wrclk_control_slave_writedata[ST_W-1:0];
      end
    end
  end

  assign event_rd                = event_reg;
  assign ienable_rd              = ienable_reg;
  assign wrclk_control_slave_irq = irq_reg;
`else
  assign event_rd                = '0;
  assign ienable_rd              = '0;
  assign wrclk_control_slave_irq = 1'b0;
`endif

endmodule

// File: tb/tb_soc_param_fifo_ctrl.sv
// Scoreboard bench for soc_param_fifo_ctrl (DEPTH=16); expectations follow SOC_FIFO_IRQ_EN when defined.
module tb_soc_param_fifo_ctrl;
  import soc_fifo_pkg::*;

  localparam int DEPTH = 16;
`ifdef SOC_FIFO_IRQ_EN
  localparam bit IRQ_BUILD = 1'b1;
`else
  localparam bit IRQ_BUILD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wr, rd;
  logic [31:0] wdata;
  logic        wr_wait, rd_wait;
  logic [31:0] rdata;
  logic [2:0]  cs_addr;
  logic        cs_rd, cs_wr;
  logic [31:0] cs_wdata, cs_rdata;
  logic        irq;

  int          vectors = 0;
  int          miscompares = 0;
  int          model_level = 0;
  logic [31:0] data_q[$];
  logic [31:0] csr_q[$];

  always #5 clk = ~clk;

  soc_param_fifo_ctrl dut (
    .wrclock                          (clk),
    .reset_n                          (reset_n),
    .avalonmm_write_slave_write       (wr),
    .avalonmm_write_slave_writedata   (wdata),
    .avalonmm_write_slave_waitrequest (wr_wait),
    .avalonmm_read_slave_read         (rd),
    .avalonmm_read_slave_readdata     (rdata),
    .avalonmm_read_slave_waitrequest  (rd_wait),
    .wrclk_control_slave_address      (cs_addr),
    .wrclk_control_slave_read         (cs_rd),
    .wrclk_control_slave_write        (cs_wr),
    .wrclk_control_slave_writedata    (cs_wdata),
    .wrclk_control_slave_readdata     (cs_rdata),
    .wrclk_control_slave_irq          (irq)
  );

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s 0x%08h", tag, got);
    end
  endtask

  function automatic logic [31:0] ev(input logic [31:0] v);
    return IRQ_BUILD ? v : 32'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic push_word(input logic [31:0] d);
    wr = 1'b1;
    wdata = d;
    @(negedge clk);
    check_value("wr_wait", 32'(wr_wait), 32'(model_level == DEPTH));
    if (model_level < DEPTH) begin
      data_q.push_back(d);
      model_level++;
    end
    tick();
    wr = 1'b0;
  endtask

  task automatic pop_word();
    rd = 1'b1;
    @(negedge clk);
    check_value("rd_wait", 32'(rd_wait), 32'(model_level == 0));
    if (model_level > 0) begin
      check_value("pop_data", rdata, data_q.pop_front());
      model_level--;
    end
    tick();
    rd = 1'b0;
  endtask

  task automatic push_pop(input logic [31:0] d);
    bit push_ok, pop_ok;
    wr = 1'b1;
    rd = 1'b1;
    wdata = d;
    push_ok = (model_level < DEPTH);
    pop_ok  = (model_level > 0);
    @(negedge clk);
    check_value("pp_wr_wait", 32'(wr_wait), 32'(!push_ok));
    check_value("pp_rd_wait", 32'(rd_wait), 32'(!pop_ok));
    if (pop_ok) check_value("pp_data", rdata, data_q.pop_front());
    if (push_ok) data_q.push_back(d);
    model_level += int'(push_ok) - int'(pop_ok);
    tick();
    wr = 1'b0;
    rd = 1'b0;
  endtask

  task automatic csr_write(input logic [2:0] a, input logic [31:0] d);
    cs_wr = 1'b1;
    cs_addr = a;
    cs_wdata = d;
    tick();
    cs_wr = 1'b0;
  endtask

  task automatic csr_read(input string tag, input logic [2:0] a, input logic [31:0] exp);
    csr_q.push_back(exp);
    cs_rd = 1'b1;
    cs_addr = a;
    tick();
    cs_rd = 1'b0;
    check_value(tag, cs_rdata, csr_q.pop_front());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; wr = 1'b0; rd = 1'b0; wdata = '0;
    cs_addr = '0; cs_rd = 1'b0; cs_wr = 1'b0; cs_wdata = '0;
    idle(2);
    reset_n = 1'b1;

    // Reset state
    check_value("rst_wr_wait", 32'(wr_wait), 32'd0);
    check_value("rst_rd_wait", 32'(rd_wait), 32'd1);
    check_value("rst_irq", 32'(irq), 32'd0);
    csr_read("rst_level", CSR_LEVEL, 32'd0);
    csr_read("rst_status", CSR_STATUS, 32'h0A);
    csr_read("rst_af_thr", CSR_AF_THR, 32'd12);
    csr_read("rst_ae_thr", CSR_AE_THR, 32'd2);
    csr_read("rst_event", CSR_EVENT, 32'd0);

    // Fill to full, overflow attempt, drain in order
    for (int i = 0; i < DEPTH; i++) push_word(32'h100 + 32'(i));
    push_word(32'h110);
    idle(2);
    csr_read("full_level", CSR_LEVEL, 32'd16);
    csr_read("full_status", CSR_STATUS, 32'h05);
    csr_read("full_event", CSR_EVENT, ev(32'h15));
    check_value("full_irq", 32'(irq), 32'd0);
    for (int i = 0; i < DEPTH; i++) pop_word();
    idle(2);
    csr_read("drain_event", CSR_EVENT, ev(32'h1F));
    csr_write(CSR_EVENT, 32'h3F);
    csr_read("w1c_event", CSR_EVENT, 32'd0);
    csr_read("drain_status", CSR_STATUS, 32'h0A);

    // Simultaneous push+pop at level 8 across pointer wrap
    for (int i = 0; i < 8; i++) push_word(32'h200 + 32'(i));
    for (int i = 0; i < 20; i++) push_pop(32'h300 + 32'(i));
    csr_read("pp_level", CSR_LEVEL, 32'd8);
    csr_read("pp_status", CSR_STATUS, 32'h00);
    for (int i = 0; i < 8; i++) pop_word();
    idle(2);
    csr_write(CSR_EVENT, 32'h3F);

    // Almost-full interrupt
    csr_write(CSR_AF_THR, 32'd4);
    csr_write(CSR_IENABLE, 32'h04);
    csr_read("af_thr", CSR_AF_THR, 32'd4);
    csr_read("ienable", CSR_IENABLE, ev(32'h04));
    for (int i = 0; i < 4; i++) push_word(32'h400 + 32'(i));
    check_value("irq_pre", 32'(irq), 32'd0);
    tick();
    check_value("irq_evt_cycle", 32'(irq), 32'd0);
    tick();
    check_value("irq_hi", 32'(irq), ev(32'd1));
    csr_read("af_event", CSR_EVENT, ev(32'h04));
    csr_read("af_status", CSR_STATUS, 32'h04);
    csr_write(CSR_EVENT, 32'h04);
    check_value("irq_hold", 32'(irq), ev(32'd1));
    tick();
    check_value("irq_clr", 32'(irq), 32'd0);
    for (int i = 0; i < 4; i++) pop_word();
    idle(2);
    csr_write(CSR_EVENT, 32'h3F);

    // Underflow
    pop_word();
    idle(2);
    csr_read("uf_event", CSR_EVENT, ev(32'h20));
    csr_read("uf_level", CSR_LEVEL, 32'd0);
    check_value("uf_irq", 32'(irq), 32'd0);
    rd = 1'b1;
    csr_read("uf_status_live", CSR_STATUS, 32'h2A);
    rd = 1'b0;

    // Reset with data held
    for (int i = 0; i < 5; i++) push_word(32'h500 + 32'(i));
    csr_read("pre_rst_level", CSR_LEVEL, 32'd5);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    data_q.delete();
    model_level = 0;
    check_value("midrst_rd_wait", 32'(rd_wait), 32'd1);
    check_value("midrst_irq", 32'(irq), 32'd0);
    csr_read("midrst_level", CSR_LEVEL, 32'd0);
    csr_read("midrst_af_thr", CSR_AF_THR, 32'd12);
    csr_read("midrst_ienable", CSR_IENABLE, 32'd0);
    csr_read("midrst_status", CSR_STATUS, 32'h0A);
    push_word(32'h600);
    pop_word();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
